// File: rtl/z_test_unit.sv
// Depth-test stage in front of the Z-buffer RAM: read/compare/write-back per fragment,
// plus a full-buffer far-plane clear sweep.
module z_test_unit #(
  parameter int X_W    = 8,
  parameter int Y_W    = 8,
  parameter int ADDR_W = X_W + Y_W,
  parameter int Z_W    = 8,
  parameter int C_W    = 8,
  parameter logic [Z_W-1:0] Z_FAR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req_i,
  output logic              clear_busy_o,
  output logic              clear_done_o,
  input  logic              frag_valid_i,
  output logic              frag_ready_o,
  input  logic [X_W-1:0]    frag_x_i,
  input  logic [Y_W-1:0]    frag_y_i,
  input  logic [Z_W-1:0]    frag_z_i,
  input  logic [C_W-1:0]    frag_color_i,
  output logic [ADDR_W-1:0] zb_read_addr_o,
  input  logic [Z_W-1:0]    zb_q_i,
  output logic [ADDR_W-1:0] zb_write_addr_o,
  output logic [Z_W-1:0]    zb_data_o,
  output logic              zb_we_o,
  output logic              pix_valid_o,
  output logic [ADDR_W-1:0] pix_addr_o,
  output logic [C_W-1:0]    pix_color_o,
  output logic [15:0]       pass_cnt_o,
  output logic [15:0]       fail_cnt_o
);

  typedef enum logic [1:0] {IDLE, RD, CMP, CLR} state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [Z_W-1:0]    z_q, z_d;
  logic [C_W-1:0]    color_q, color_d;
  logic [ADDR_W:0]   clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] zb_read_addr_q, zb_read_addr_d;
  logic [ADDR_W-1:0] zb_write_addr_q, zb_write_addr_d;
  logic [Z_W-1:0]    zb_data_q, zb_data_d;
  logic              zb_we_q, zb_we_d;
  logic              pix_valid_q, pix_valid_d;
  logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
  logic [C_W-1:0]    pix_color_q, pix_color_d;
  logic [15:0]       pass_cnt_q, pass_cnt_d;
  logic [15:0]       fail_cnt_q, fail_cnt_d;
  logic              clear_busy_q, clear_busy_d;
  logic              clear_done_q, clear_done_d;

  logic clr_start, accept, clr_last, z_pass;

  // run_q keeps the unit quiet (frag_ready low) for the first cycle out of reset
  assign clr_start    = run_q && (state_q == IDLE) && clear_req_i;
  assign frag_ready_o = run_q && (state_q == IDLE) && !clear_req_i;
  assign accept       = frag_valid_i && frag_ready_o;
  assign clr_last     = clr_cnt_q[ADDR_W];
  assign z_pass       = z_q < zb_q_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      run_q           <= 1'b0;
      addr_q          <= '0;
      z_q             <= '0;
      color_q         <= '0;
      clr_cnt_q       <= '0;
      zb_read_addr_q  <= '0;
      zb_write_addr_q <= '0;
      zb_data_q       <= '0;
      zb_we_q         <= 1'b0;
      pix_valid_q     <= 1'b0;
      pix_addr_q      <= '0;
      pix_color_q     <= '0;
      pass_cnt_q      <= '0;
      fail_cnt_q      <= '0;
      clear_busy_q    <= 1'b0;
      clear_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_q           <= 1'b1;
      addr_q          <= addr_d;
      z_q             <= z_d;
      color_q         <= color_d;
      clr_cnt_q       <= clr_cnt_d;
      zb_read_addr_q  <= zb_read_addr_d;
      zb_write_addr_q <= zb_write_addr_d;
      zb_data_q       <= zb_data_d;
      zb_we_q         <= zb_we_d;
      pix_valid_q     <= pix_valid_d;
      pix_addr_q      <= pix_addr_d;
      pix_color_q     <= pix_color_d;
      pass_cnt_q      <= pass_cnt_d;
      fail_cnt_q      <= fail_cnt_d;
      clear_busy_q    <= clear_busy_d;
      clear_done_q    <= clear_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clr_start)   state_d = CLR;
        else if (accept) state_d = RD;
      end
      RD:  state_d = CMP;
      CMP: state_d = IDLE;
      CLR: if (clr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d          = addr_q;
    z_d             = z_q;
    color_d         = color_q;
    clr_cnt_d       = clr_cnt_q;
    zb_read_addr_d  = zb_read_addr_q;
    zb_write_addr_d = zb_write_addr_q;
    zb_data_d       = zb_data_q;
    zb_we_d         = 1'b0;
    pix_valid_d     = 1'b0;
    pix_addr_d      = '0;
    pix_color_d     = '0;
    pass_cnt_d      = pass_cnt_q;
    fail_cnt_d      = fail_cnt_q;
    clear_busy_d    = clear_busy_q;
    clear_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          // address 0 goes out on the entry edge, so the counter starts at 1
          clear_busy_d    = 1'b1;
          clr_cnt_d       = (ADDR_W+1)'(1);
          zb_we_d         = 1'b1;
          zb_write_addr_d = '0;
          zb_data_d       = Z_FAR;
        end else if (accept) begin
          addr_d         = {frag_y_i, frag_x_i};
          z_d            = frag_z_i;
          color_d        = frag_color_i;
          zb_read_addr_d = {frag_y_i, frag_x_i};
        end
      end
      CMP: begin
        if (z_pass) begin
          zb_we_d         = 1'b1;
          zb_write_addr_d = addr_q;
          zb_data_d       = z_q;
          pix_valid_d     = 1'b1;
          pix_addr_d      = addr_q;
          pix_color_d     = color_q;
          pass_cnt_d      = (pass_cnt_q == 16'hFFFF) ? pass_cnt_q : pass_cnt_q + 16'd1;
        end else begin
          fail_cnt_d      = (fail_cnt_q == 16'hFFFF) ? fail_cnt_q : fail_cnt_q + 16'd1;
        end
      end
      CLR: begin
        if (clr_last) begin
          clear_busy_d = 1'b0;
          clear_done_d = 1'b1;
        end else begin
          zb_we_d         = 1'b1;
          zb_write_addr_d = clr_cnt_q[ADDR_W-1:0];
          zb_data_d       = Z_FAR;
          clr_cnt_d       = clr_cnt_q + (ADDR_W+1)'(1);
        end
      end
      default: ;
    endcase
  end

  assign clear_busy_o    = clear_busy_q;
  assign clear_done_o    = clear_done_q;
  assign zb_read_addr_o  = zb_read_addr_q;
  assign zb_write_addr_o = zb_write_addr_q;
  assign zb_data_o       = zb_data_q;
  assign zb_we_o         = zb_we_q;
  assign pix_valid_o     = pix_valid_q;
  assign pix_addr_o      = pix_addr_q;
  assign pix_color_o     = pix_color_q;
  assign pass_cnt_o      = pass_cnt_q;
  assign fail_cnt_o      = fail_cnt_q;

endmodule

// File: tb/tb_z_test_unit.sv
// Directed bench for z_test_unit with a behavioural single-clock Z-buffer RAM.
module tb_z_test_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        clear_busy, clear_done;
  logic        frag_valid = 1'b0;
  logic        frag_ready;
  logic [7:0]  frag_x = '0, frag_y = '0, frag_z = '0, frag_color = '0;
  logic [15:0] zb_read_addr, zb_write_addr, pix_addr;
  logic [7:0]  zb_q = '0, zb_data, pix_color;
  logic        zb_we, pix_valid;
  logic [15:0] pass_cnt, fail_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:65535];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (zb_we) mem[zb_write_addr] <= zb_data;
    zb_q <= mem[zb_read_addr];
  end

  z_test_unit dut (
    .clk(clk), .rst_n(rst_n),
    .clear_req_i(clear_req), .clear_busy_o(clear_busy), .clear_done_o(clear_done),
    .frag_valid_i(frag_valid), .frag_ready_o(frag_ready),
    .frag_x_i(frag_x), .frag_y_i(frag_y), .frag_z_i(frag_z), .frag_color_i(frag_color),
    .zb_read_addr_o(zb_read_addr), .zb_q_i(zb_q),
    .zb_write_addr_o(zb_write_addr), .zb_data_o(zb_data), .zb_we_o(zb_we),
    .pix_valid_o(pix_valid), .pix_addr_o(pix_addr), .pix_color_o(pix_color),
    .pass_cnt_o(pass_cnt), .fail_cnt_o(fail_cnt)
  );

  // Drives one fragment and returns at the negedge of the IDLE cycle after CMP.
  task automatic send_frag(input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] z, input logic [7:0] c);
    @(negedge clk);
    frag_x = x; frag_y = y; frag_z = z; frag_color = c; frag_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frag_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [127:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {clear_busy, clear_done, zb_read_addr, zb_write_addr, zb_data, zb_we,
            pix_valid, pix_addr, pix_color, pass_cnt, fail_cnt};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL reset_outs: got %h exp 0", outs); end
    checks++;
    if (frag_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b exp 0", frag_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (frag_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b exp 1", frag_ready); end
  endtask

  task automatic test_clear_wins;
    int n = 0;
    int bad = 0;
    @(negedge clk);
    frag_x = 8'h32; frag_y = 8'h32; frag_z = 8'h40; frag_color = 8'hA0;
    frag_valid = 1'b1; clear_req = 1'b1;
    #1;
    checks++;
    if (frag_ready !== 1'b0) begin failures++; $display("FAIL clr_prio_ready: got %b exp 0", frag_ready); end
    @(negedge clk);
    clear_req = 1'b0;
    checks++;
    if ({clear_busy, zb_we, zb_write_addr, zb_data} !== {1'b1, 1'b1, 16'h0000, 8'hFF}) begin
      failures++;
      $display("FAIL clr_first: got busy=%b we=%b a=%h d=%h exp 1 1 0000 ff", clear_busy, zb_we, zb_write_addr, zb_data);
    end
    while (clear_busy === 1'b1 && n < 70000) begin
      if (zb_we !== 1'b1 || zb_write_addr !== 16'(n) || zb_data !== 8'hFF || frag_ready !== 1'b0 ||
          clear_done !== 1'b0 || pix_valid !== 1'b0 || pix_addr !== 16'h0 || zb_read_addr !== 16'h0)
        bad++;
      clear_req = (n == 1000);
      @(negedge clk);
      n++;
    end
    clear_req = 1'b0;
    checks++;
    if (n !== 65536) begin failures++; $display("FAIL clr_len: got %0d exp 65536", n); end
    checks++;
    if (bad !== 0) begin failures++; $display("FAIL clr_sweep: got %0d bad cycles exp 0", bad); end
    checks++;
    if ({clear_done, frag_ready, zb_we} !== 3'b110) begin
      failures++; $display("FAIL clr_done: got done/ready/we=%b%b%b exp 110", clear_done, frag_ready, zb_we);
    end
    // the held fragment is accepted on this edge
    @(negedge clk);
    frag_valid = 1'b0;
    checks++;
    if (zb_read_addr !== 16'h3232) begin failures++; $display("FAIL frag1_raddr: got %h exp 3232", zb_read_addr); end
    checks++;
    if (clear_done !== 1'b0) begin failures++; $display("FAIL clr_done_pulse: got %b exp 0", clear_done); end
    @(negedge clk);
    checks++;
    if (zb_we !== 1'b0) begin failures++; $display("FAIL frag1_early_we: got %b exp 0", zb_we); end
    @(negedge clk);
    checks++;
    if ({zb_we, zb_write_addr, zb_data, pix_valid, pix_addr, pix_color, pass_cnt} !==
        {1'b1, 16'h3232, 8'h40, 1'b1, 16'h3232, 8'hA0, 16'd1}) begin
      failures++;
      $display("FAIL frag1_pass: got we=%b wa=%h d=%h pv=%b pa=%h pc=%h pass=%0d exp 1 3232 40 1 3232 a0 1",
               zb_we, zb_write_addr, zb_data, pix_valid, pix_addr, pix_color, pass_cnt);
    end
    @(negedge clk);
    checks++;
    if ({zb_we, pix_valid} !== 2'b00) begin failures++; $display("FAIL frag1_pulse: got %b%b exp 00", zb_we, pix_valid); end
  endtask

  task automatic test_depth_compare;
    send_frag(8'h32, 8'h32, 8'h40, 8'h11);
    checks++;
    if ({zb_we, pix_valid, fail_cnt} !== {2'b00, 16'd1}) begin
      failures++; $display("FAIL equal_rej: got we=%b pv=%b fail=%0d exp 0 0 1", zb_we, pix_valid, fail_cnt);
    end
    send_frag(8'h32, 8'h32, 8'h50, 8'h11);
    checks++;
    if ({zb_we, pix_valid, fail_cnt, pass_cnt} !== {2'b00, 16'd2, 16'd1}) begin
      failures++; $display("FAIL far_rej: got we=%b pv=%b fail=%0d pass=%0d exp 0 0 2 1", zb_we, pix_valid, fail_cnt, pass_cnt);
    end
    send_frag(8'h32, 8'h32, 8'h10, 8'h22);
    checks++;
    if ({zb_we, zb_data, pix_color, pass_cnt} !== {1'b1, 8'h10, 8'h22, 16'd2}) begin
      failures++; $display("FAIL near_pass: got we=%b d=%h pc=%h pass=%0d exp 1 10 22 2", zb_we, zb_data, pix_color, pass_cnt);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    frag_x = 8'h64; frag_y = 8'h64; frag_z = 8'h80; frag_color = 8'h55; frag_valid = 1'b1;
    @(negedge clk);
    frag_z = 8'h90; frag_color = 8'h66;
    checks++;
    if ({zb_read_addr, frag_ready} !== {16'h6464, 1'b0}) begin
      failures++; $display("FAIL b2b_first: got ra=%h rdy=%b exp 6464 0", zb_read_addr, frag_ready);
    end
    @(negedge clk);
    checks++;
    if (frag_ready !== 1'b0) begin failures++; $display("FAIL b2b_cmp_ready: got %b exp 0", frag_ready); end
    @(negedge clk);
    checks++;
    if ({zb_we, zb_data, frag_ready, pass_cnt} !== {1'b1, 8'h80, 1'b1, 16'd3}) begin
      failures++; $display("FAIL b2b_pass: got we=%b d=%h rdy=%b pass=%0d exp 1 80 1 3", zb_we, zb_data, frag_ready, pass_cnt);
    end
    @(negedge clk);
    frag_valid = 1'b0;
    checks++;
    if (frag_ready !== 1'b0) begin failures++; $display("FAIL b2b_second_acc: got %b exp 0", frag_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({zb_we, pix_valid, fail_cnt, pass_cnt} !== {2'b00, 16'd3, 16'd3}) begin
      failures++; $display("FAIL b2b_reject: got we=%b pv=%b fail=%0d pass=%0d exp 0 0 3 3", zb_we, pix_valid, fail_cnt, pass_cnt);
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [127:0] outs;
    int seen = 0;
    @(negedge clk);
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    repeat (99) @(negedge clk);
    checks++;
    if ({clear_busy, zb_we, zb_write_addr} !== {2'b11, 16'd99}) begin
      failures++; $display("FAIL mid_clr: got busy=%b we=%b wa=%h exp 1 1 0063", clear_busy, zb_we, zb_write_addr);
    end
    rst_n = 1'b0;
    #1;
    outs = {clear_busy, clear_done, zb_read_addr, zb_write_addr, zb_data, zb_we,
            pix_valid, pix_addr, pix_color, pass_cnt, fail_cnt, frag_ready};
    checks++;
    if (outs !== '0) begin failures++; $display("FAIL abort_outs: got %h exp 0", outs); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (clear_done !== 1'b0 || clear_busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_done: got %0d cycles exp 0", seen); end
    send_frag(8'h64, 8'h64, 8'h70, 8'h33);
    checks++;
    if ({zb_we, zb_write_addr, zb_data, pass_cnt, fail_cnt} !== {1'b1, 16'h6464, 8'h70, 16'd1, 16'd0}) begin
      failures++; $display("FAIL post_rst_pass: got we=%b wa=%h d=%h pass=%0d fail=%0d exp 1 6464 70 1 0",
                           zb_we, zb_write_addr, zb_data, pass_cnt, fail_cnt);
    end
    send_frag(8'h32, 8'h32, 8'h20, 8'h44);
    checks++;
    if ({zb_we, pix_valid, fail_cnt} !== {2'b00, 16'd1}) begin
      failures++; $display("FAIL post_rst_rej: got we=%b pv=%b fail=%0d exp 0 0 1", zb_we, pix_valid, fail_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_clear_wins();
    test_depth_compare();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
